cr_sa_cnt_bank: RTL and testbench

Parametrised statistics-aggregator counter bank. It is the next generation of the fixed 64 x 50-bit SA counter block and sits behind the SA regfile. It holds N_CNT live counters with multi-unit increments, per-counter enable, saturate/wrap mode and sticky overflow flags. It supports global atomic snapshot and clear-live, and a handshaked indirect-access port for reading live or snapshot values and clearing single counters.

---
 rtl/cr_sa_cnt_bank_pkg.sv | 30 +++
 rtl/cr_sa_cnt_bank_if.sv | 32 +++
 rtl/cr_sa_cnt_bank_cell.sv | 60 ++++++
 rtl/cr_sa_cnt_bank.sv | 147 ++++++++++++++
 tb/tb_cr_sa_cnt_bank.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_sa_cnt_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cr_sa_cnt_bank_pkg
// Brief   : Shared types for the statistics-aggregator counter bank.
// Revision: 1.0 - initial release
// ============================================================================
package cr_sa_cnt_bank_pkg;

    typedef enum logic [1:0] {
        RD_LIVE = 2'd0,
        RD_SNAP = 2'd1,
        CLR_ONE = 2'd2,
        OP_RSVD = 2'd3
    } ia_op_e;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        OK_OVF   = 2'd1,
        ERR_ADDR = 2'd2,
        ERR_OP   = 2'd3
    } ia_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sa_cnt_state_e;

endpackage
`default_nettype wire

// File: rtl/cr_sa_cnt_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : cr_sa_cnt_bank_if
// Brief   : Indirect-access command/response handshake for the counter bank.
// Revision: 1.0 - initial release
// ============================================================================
interface cr_sa_cnt_bank_if
    import cr_sa_cnt_bank_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int CNT_WIDTH = 50
);
    logic                 ia_cmd_vld;
    logic                 ia_cmd_rdy;
    ia_op_e               ia_cmd_op;
    logic [ADDR_W-1:0]    ia_cmd_addr;
    logic                 ia_rsp_vld;
    logic                 ia_rsp_rdy;
    ia_code_e             ia_rsp_code;
    logic [CNT_WIDTH-1:0] ia_rsp_data;

    modport master (
        output ia_cmd_vld, ia_cmd_op, ia_cmd_addr, ia_rsp_rdy,
        input  ia_cmd_rdy, ia_rsp_vld, ia_rsp_code, ia_rsp_data
    );

    modport slave (
        input  ia_cmd_vld, ia_cmd_op, ia_cmd_addr, ia_rsp_rdy,
        output ia_cmd_rdy, ia_rsp_vld, ia_rsp_code, ia_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/cr_sa_cnt_bank_cell.sv
`default_nettype none
// ============================================================================
// Module  : cr_sa_cnt_cell
// Brief   : One live counter with snapshot and sticky overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
module cr_sa_cnt_cell #(
    parameter int CNT_WIDTH = 50,
    parameter int INC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc_en,
    input  logic [INC_WIDTH-1:0] i_inc_amt,
    input  logic                 i_cnt_enable,
    input  logic                 i_sat_mode,
    input  logic                 i_snap,
    input  logic                 i_clear,
    output logic [CNT_WIDTH-1:0] o_live,
    output logic [CNT_WIDTH-1:0] o_snap,
    output logic                 o_ovf
);

    logic [CNT_WIDTH-1:0] r_live;
    logic [CNT_WIDTH-1:0] r_snap;
    logic                 r_ovf;
    logic [CNT_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_live} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, i_inc_amt};

    // Snapshot samples the pre-edge value, so snap+clear forms an atomic read-and-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= '0;
            r_snap <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_snap) begin
                r_snap <= r_live;
            end
            if (i_clear) begin
                r_live <= '0;
                r_ovf  <= 1'b0;
            end else if (i_inc_en && i_cnt_enable) begin
                if (w_sum[CNT_WIDTH]) begin
                    r_ovf  <= 1'b1;
                    r_live <= i_sat_mode ? {CNT_WIDTH{1'b1}} : w_sum[CNT_WIDTH-1:0];
                end else begin
                    r_live <= w_sum[CNT_WIDTH-1:0];
                end
            end
        end
    end

    assign o_live = r_live;
    assign o_snap = r_snap;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/cr_sa_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module  : cr_sa_cnt_bank
// Brief   : Parametrised SA counter bank with snapshot and indirect access.
// Revision: 1.0 - initial release
// ============================================================================
module cr_sa_cnt_bank
    import cr_sa_cnt_bank_pkg::*;
#(
    parameter int N_CNT     = 64,
    parameter int CNT_WIDTH = 50,
    parameter int INC_WIDTH = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CNT-1:0]           inc_en,
    input  logic [N_CNT*INC_WIDTH-1:0] inc_amt,
    input  logic [N_CNT-1:0]           cfg_cnt_enable,
    input  logic [N_CNT-1:0]           cfg_sat_mode,
    input  logic                       snap_req,
    input  logic                       clear_live_req,
    cr_sa_cnt_bank_if.slave            ia,
    output logic [N_CNT-1:0]           ovf_sticky
);

    localparam logic [ADDR_W:0] c_N_CNT = (ADDR_W + 1)'(N_CNT);

    generate
        if (ADDR_W != $clog2(N_CNT)) begin : g_addr_w_chk
            $error("cr_sa_cnt_bank: ADDR_W must equal $clog2(N_CNT)");
        end
    endgenerate

    sa_cnt_state_e        r_state;
    ia_op_e               r_op;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_rsp_vld;
    ia_code_e             r_rsp_code;
    logic [CNT_WIDTH-1:0] r_rsp_data;

    logic [CNT_WIDTH-1:0] w_live [N_CNT];
    logic [CNT_WIDTH-1:0] w_snap [N_CNT];
    logic                 w_addr_ok;
    logic                 w_clr_one;
    logic [CNT_WIDTH-1:0] w_rd_live;
    logic [CNT_WIDTH-1:0] w_rd_snap;
    logic                 w_rd_ovf;

    assign w_addr_ok = ({1'b0, r_addr} < c_N_CNT);
    assign w_clr_one = (r_state == EXEC) && (r_op == CLR_ONE) && w_addr_ok;

    always_comb begin
        w_rd_live = '0;
        w_rd_snap = '0;
        w_rd_ovf  = 1'b0;
        if (w_addr_ok) begin
            w_rd_live = w_live[r_addr];
            w_rd_snap = w_snap[r_addr];
            w_rd_ovf  = ovf_sticky[r_addr];
        end
    end

    generate
        for (genvar i = 0; i < N_CNT; i++) begin : g_cell
            logic w_clear;
            assign w_clear = clear_live_req || (w_clr_one && (r_addr == ADDR_W'(i)));

            cr_sa_cnt_cell #(
                .CNT_WIDTH (CNT_WIDTH),
                .INC_WIDTH (INC_WIDTH)
            ) u_cell (
                .clk          (clk),
                .rst          (rst),
                .i_inc_en     (inc_en[i]),
                .i_inc_amt    (inc_amt[i*INC_WIDTH +: INC_WIDTH]),
                .i_cnt_enable (cfg_cnt_enable[i]),
                .i_sat_mode   (cfg_sat_mode[i]),
                .i_snap       (snap_req),
                .i_clear      (w_clear),
                .o_live       (w_live[i]),
                .o_snap       (w_snap[i]),
                .o_ovf        (ovf_sticky[i])
            );
        end
    endgenerate

    // Reads sample pre-edge state in EXEC; op error outranks address error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= RD_LIVE;
            r_addr     <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_code <= OK;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ia.ia_cmd_vld) begin
                        r_op    <= ia.ia_cmd_op;
                        r_addr  <= ia.ia_cmd_addr;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_vld <= 1'b1;
                    r_state   <= RESP;
                    if (r_op == OP_RSVD) begin
                        r_rsp_code <= ERR_OP;
                        r_rsp_data <= '0;
                    end else if (!w_addr_ok) begin
                        r_rsp_code <= ERR_ADDR;
                        r_rsp_data <= '0;
                    end else if (r_op == RD_LIVE) begin
                        r_rsp_code <= w_rd_ovf ? OK_OVF : OK;
                        r_rsp_data <= w_rd_live;
                    end else if (r_op == RD_SNAP) begin
                        r_rsp_code <= w_rd_ovf ? OK_OVF : OK;
                        r_rsp_data <= w_rd_snap;
                    end else begin
                        r_rsp_code <= OK;
                        r_rsp_data <= '0;
                    end
                end
                RESP: begin
                    if (ia.ia_rsp_rdy) begin
                        r_rsp_vld  <= 1'b0;
                        r_rsp_code <= OK;
                        r_rsp_data <= '0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ia.ia_cmd_rdy  = (r_state == IDLE);
    assign ia.ia_rsp_vld  = r_rsp_vld;
    assign ia.ia_rsp_code = r_rsp_code;
    assign ia.ia_rsp_data = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_cr_sa_cnt_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_cr_sa_cnt_bank
// Brief   : Self-checking bench for cr_sa_cnt_bank (48 x 8-bit counters).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cr_sa_cnt_bank;
    import cr_sa_cnt_bank_pkg::*;

    localparam int N_CNT     = 48;
    localparam int CNT_WIDTH = 8;
    localparam int INC_WIDTH = 8;
    localparam int ADDR_W    = 6;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N_CNT-1:0]           inc_en;
    logic [N_CNT*INC_WIDTH-1:0] inc_amt;
    logic [N_CNT-1:0]           cfg_cnt_enable;
    logic [N_CNT-1:0]           cfg_sat_mode;
    logic                       snap_req;
    logic                       clear_live_req;
    logic [N_CNT-1:0]           ovf_sticky;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_code_q [$];
    logic [7:0] exp_data_q [$];

    cr_sa_cnt_bank_if #(.ADDR_W(ADDR_W), .CNT_WIDTH(CNT_WIDTH)) ia ();

    cr_sa_cnt_bank #(
        .N_CNT     (N_CNT),
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (INC_WIDTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inc_en         (inc_en),
        .inc_amt        (inc_amt),
        .cfg_cnt_enable (cfg_cnt_enable),
        .cfg_sat_mode   (cfg_sat_mode),
        .snap_req       (snap_req),
        .clear_live_req (clear_live_req),
        .ia             (ia.slave),
        .ovf_sticky     (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inc_one(input int idx, input logic [7:0] amt);
        inc_en[idx] = 1'b1;
        inc_amt[idx*INC_WIDTH +: INC_WIDTH] = amt;
        tick();
        inc_en  = '0;
        inc_amt = '0;
    endtask

    // Push expectation, issue command, pop and compare when the response appears.
    task automatic do_cmd(input logic [1:0] op, input logic [5:0] addr,
                          input logic [1:0] ecode, input logic [7:0] edata,
                          input int inc_idx, input logic [7:0] iamt, input int hold);
        int n;
        logic [1:0] ec;
        logic [7:0] ed;
        exp_code_q.push_back(ecode);
        exp_data_q.push_back(edata);
        n = 0;
        while (!ia.ia_cmd_rdy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ia.ia_cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL cmd_rdy_wait: got %0b expected 1", ia.ia_cmd_rdy);
        end
        ia.ia_cmd_vld  = 1'b1;
        ia.ia_cmd_op   = ia_op_e'(op);
        ia.ia_cmd_addr = addr;
        tick();
        ia.ia_cmd_vld = 1'b0;
        n = 1;
        if (inc_idx >= 0) begin
            inc_en[inc_idx] = 1'b1;
            inc_amt[inc_idx*INC_WIDTH +: INC_WIDTH] = iamt;
        end
        while (!ia.ia_rsp_vld && n < 8) begin
            tick();
            inc_en  = '0;
            inc_amt = '0;
            n++;
        end
        inc_en  = '0;
        inc_amt = '0;
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL rsp_latency op%0d addr%0d: got %0d edges expected 2", op, addr, n);
        end
        if (hold > 0) begin
            ia.ia_rsp_rdy = 1'b0;
            for (int k = 0; k < hold; k++) begin
                tick();
                checks++;
                if (ia.ia_rsp_vld !== 1'b1 || ia.ia_cmd_rdy !== 1'b0 ||
                    ia.ia_rsp_code !== exp_code_q[0] || ia.ia_rsp_data !== exp_data_q[0]) begin
                    errors++;
                    $display("FAIL rsp_hold cycle %0d: got vld %0b rdy %0b code %0d data %0d expected vld 1 rdy 0 code %0d data %0d",
                             k, ia.ia_rsp_vld, ia.ia_cmd_rdy, ia.ia_rsp_code, ia.ia_rsp_data,
                             exp_code_q[0], exp_data_q[0]);
                end
            end
            ia.ia_rsp_rdy = 1'b1;
        end
        ec = exp_code_q.pop_front();
        ed = exp_data_q.pop_front();
        checks++;
        if (ia.ia_rsp_code !== ec) begin
            errors++;
            $display("FAIL rsp_code op%0d addr%0d: got %0d expected %0d", op, addr, ia.ia_rsp_code, ec);
        end
        checks++;
        if (ia.ia_rsp_data !== ed) begin
            errors++;
            $display("FAIL rsp_data op%0d addr%0d: got %0d expected %0d", op, addr, ia.ia_rsp_data, ed);
        end
        tick();
        checks++;
        if (ia.ia_rsp_vld !== 1'b0 || ia.ia_rsp_code !== OK || ia.ia_rsp_data !== 8'd0 ||
            ia.ia_cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rsp_release: got vld %0b code %0d data %0d rdy %0b expected 0 0 0 1",
                     ia.ia_rsp_vld, ia.ia_rsp_code, ia.ia_rsp_data, ia.ia_cmd_rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ovf_sticky !== '0) begin
            errors++;
            $display("FAIL reset_ovf: got %0h expected 0", ovf_sticky);
        end
        checks++;
        if (ia.ia_cmd_rdy !== 1'b1 || ia.ia_rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got rdy %0b vld %0b expected 1 0", ia.ia_cmd_rdy, ia.ia_rsp_vld);
        end
        checks++;
        if (ia.ia_rsp_code !== OK || ia.ia_rsp_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_rsp: got code %0d data %0d expected 0 0", ia.ia_rsp_code, ia.ia_rsp_data);
        end
        do_cmd(2'd0, 6'd0, 2'd0, 8'd0, -1, 8'd0, 0);
    endtask

    task automatic test_saturate();
        cfg_sat_mode[3] = 1'b1;
        inc_one(3, 8'd250);
        checks++;
        if (ovf_sticky[3] !== 1'b0) begin
            errors++;
            $display("FAIL sat_pre_ovf: got %0b expected 0", ovf_sticky[3]);
        end
        inc_one(3, 8'd10);
        checks++;
        if (ovf_sticky[3] !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf: got %0b expected 1", ovf_sticky[3]);
        end
        do_cmd(2'd0, 6'd3, 2'd1, 8'd255, -1, 8'd0, 0);
        inc_one(3, 8'd7);
        do_cmd(2'd0, 6'd3, 2'd1, 8'd255, -1, 8'd0, 0);
    endtask

    task automatic test_wrap_clear();
        inc_one(5, 8'd250);
        inc_one(5, 8'd10);
        checks++;
        if (ovf_sticky !== 48'h28) begin
            errors++;
            $display("FAIL wrap_ovf_vec: got %0h expected 28", ovf_sticky);
        end
        do_cmd(2'd0, 6'd5, 2'd1, 8'd4, -1, 8'd0, 0);
        clear_live_req = 1'b1;
        tick();
        clear_live_req = 1'b0;
        checks++;
        if (ovf_sticky !== '0) begin
            errors++;
            $display("FAIL clear_ovf: got %0h expected 0", ovf_sticky);
        end
        do_cmd(2'd0, 6'd5, 2'd0, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd0, 6'd3, 2'd0, 8'd0, -1, 8'd0, 0);
    endtask

    task automatic test_snapshot();
        inc_one(7, 8'd100);
        snap_req = 1'b1;
        clear_live_req = 1'b1;
        inc_en[7] = 1'b1;
        inc_amt[7*INC_WIDTH +: INC_WIDTH] = 8'd5;
        tick();
        snap_req = 1'b0;
        clear_live_req = 1'b0;
        inc_en  = '0;
        inc_amt = '0;
        do_cmd(2'd1, 6'd7, 2'd0, 8'd100, -1, 8'd0, 0);
        do_cmd(2'd0, 6'd7, 2'd0, 8'd0, -1, 8'd0, 0);
        inc_one(7, 8'd9);
        snap_req = 1'b1;
        inc_one(7, 8'd1);
        snap_req = 1'b0;
        do_cmd(2'd1, 6'd7, 2'd0, 8'd9, -1, 8'd0, 0);
        do_cmd(2'd0, 6'd7, 2'd0, 8'd10, -1, 8'd0, 0);
    endtask

    task automatic test_errors();
        inc_one(10, 8'd33);
        cfg_cnt_enable[10] = 1'b0;
        inc_one(10, 8'd50);
        cfg_cnt_enable[10] = 1'b1;
        inc_one(10, 8'd0);
        do_cmd(2'd0, 6'd50, 2'd2, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd3, 6'd50, 2'd3, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd3, 6'd10, 2'd3, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd2, 6'd50, 2'd2, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd0, 6'd47, 2'd0, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd0, 6'd10, 2'd0, 8'd33, -1, 8'd0, 0);
    endtask

    task automatic test_clr_one();
        inc_one(2, 8'd40);
        do_cmd(2'd0, 6'd2, 2'd0, 8'd40, -1, 8'd0, 0);
        do_cmd(2'd2, 6'd2, 2'd0, 8'd0, 2, 8'd3, 0);
        do_cmd(2'd0, 6'd2, 2'd0, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd0, 6'd10, 2'd0, 8'd33, -1, 8'd0, 0);
    endtask

    task automatic test_hold_and_reset();
        do_cmd(2'd0, 6'd10, 2'd0, 8'd33, -1, 8'd0, 10);
        inc_one(5, 8'd250);
        inc_one(5, 8'd10);
        checks++;
        if (ovf_sticky[5] !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_ovf: got %0b expected 1", ovf_sticky[5]);
        end
        ia.ia_cmd_vld  = 1'b1;
        ia.ia_cmd_op   = RD_LIVE;
        ia.ia_cmd_addr = 6'd5;
        tick();
        ia.ia_cmd_vld = 1'b0;
        ia.ia_rsp_rdy = 1'b0;
        tick();
        tick();
        checks++;
        if (ia.ia_rsp_vld !== 1'b1) begin
            errors++;
            $display("FAIL resp_before_rst: got %0b expected 1", ia.ia_rsp_vld);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ia.ia_rsp_vld !== 1'b0 || ovf_sticky !== '0 || ia.ia_cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL async_rst: got vld %0b ovf %0h rdy %0b expected 0 0 1",
                     ia.ia_rsp_vld, ovf_sticky, ia.ia_cmd_rdy);
        end
        tick();
        rst = 1'b0;
        ia.ia_rsp_rdy = 1'b1;
        tick();
        checks++;
        if (ia.ia_cmd_rdy !== 1'b1 || ia.ia_rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_hs: got rdy %0b vld %0b expected 1 0", ia.ia_cmd_rdy, ia.ia_rsp_vld);
        end
        do_cmd(2'd0, 6'd5, 2'd0, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd0, 6'd10, 2'd0, 8'd0, -1, 8'd0, 0);
        do_cmd(2'd1, 6'd7, 2'd0, 8'd0, -1, 8'd0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        inc_en         = '0;
        inc_amt        = '0;
        cfg_cnt_enable = '1;
        cfg_sat_mode   = '0;
        snap_req       = 1'b0;
        clear_live_req = 1'b0;
        ia.ia_cmd_vld  = 1'b0;
        ia.ia_cmd_op   = RD_LIVE;
        ia.ia_cmd_addr = '0;
        ia.ia_rsp_rdy  = 1'b1;
        test_reset();
        test_saturate();
        test_wrap_clear();
        test_snapshot();
        test_errors();
        test_clr_one();
        test_hold_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
